lab7_soc_leds: RTL and testbench
================================

LAB7_SOC_LEDS -- requirements
Module: lab7_soc_leds

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the output port width in bits (1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the data register value at reset.
REQ-003 The block SHALL have parameter BLINK_DIV, default 25_000_000, giving the clock cycles per blink half-period (>=1).
REQ-004 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port address  input  2  Avalon-MM word address.
REQ-007 The block SHALL have port chipselect  input  1  slave select, active-high.
REQ-008 The block SHALL have port write_n  input  1  write strobe, active-low, qualified by chipselect.
REQ-009 The block SHALL have port writedata  input  32  write data; bits [WIDTH-1:0] used.
REQ-010 The block SHALL have port byteenable  input  4  byte lanes of writedata; a disabled lane leaves its target bits unchanged.
REQ-011 The block SHALL have port readdata  output  32  registered read data, read latency 1.
REQ-012 The block SHALL have port out_port  output  WIDTH  LED drive.

Function
REQ-013 A write SHALL occur on a rising edge with chipselect=1 and write_n=0; there are no wait states.
REQ-014 A write to address 0 SHALL load data_reg with writedata in the enabled lanes.
REQ-015 A write to address 1 SHALL load blink_mask in the enabled lanes, clear the prescaler count to 0, and clear phase to 0 on the same edge.
REQ-016 A write to address 2 SHALL set bits: data_reg |= writedata in the enabled lanes.
REQ-017 A write to address 3 SHALL clear bits: data_reg &= ~writedata in the enabled lanes.
REQ-018 readdata SHALL update every edge, independent of chipselect.
REQ-019 The readdata value SHALL be selected by address: 0 -> data_reg; 1 -> blink_mask; 2 -> {31'b0, phase}; 3 -> 0.
REQ-020 Bits of readdata above WIDTH SHALL read as zero.
REQ-021 A read of a register written on the same edge SHALL return the pre-write value.
REQ-022 The prescaler SHALL count 0..BLINK_DIV-1.
REQ-023 At count BLINK_DIV-1 the prescaler SHALL wrap to 0 and toggle phase on that edge; with BLINK_DIV=1, phase toggles every cycle.
REQ-024 A write to address 1 SHALL take priority over a prescaler wrap on the same edge.
REQ-025 out_port SHALL be data_reg XOR (blink_mask AND {WIDTH{phase}}), driven combinationally from flops only, with no input-to-output path.
REQ-026 out_port SHALL reflect a write immediately after the write edge.
REQ-027 Bits with blink_mask=0 SHALL be static at data_reg.

Reset
REQ-028 While reset=1, the block SHALL hold data_reg=RESET_VALUE, blink_mask=0, count=0, phase=0, and readdata=0; out_port therefore equals RESET_VALUE.
REQ-029 Reset asserted mid-blink SHALL clear state immediately, and the counter SHALL restart from 0 on the first edge after deassertion.

Structure
REQ-030 Address constants (ADDR_DATA=0, ADDR_MASK=1, ADDR_SET=2, ADDR_CLR=3) and the byte-lane merge function SHALL live in shared package lab7_soc_pio_pkg.
REQ-031 The prescaler and phase logic SHALL be sub-module lab7_soc_blink_prescaler, with ports clk, reset, restart, and phase.

Verification
REQ-032 Write 0x00A5 to address 0 with byteenable 0011 -> out_port=0x00A5 after the edge, and readdata=0x000000A5 one cycle after a read of address 0.
REQ-033 With data_reg=0x00F0, write 0x0003 to address 2, then 0x0010 to address 3 -> out_port=0x00F3, then 0x00E3.
REQ-034 With byteenable 0010, write 0xFFFF to address 0 while data_reg=0x1234 -> data_reg=0xFF34.
REQ-035 BLINK_DIV=4, mask 0x0001, data 0 -> out_port bit0 toggles every 4 cycles, and address-2 reads alternate 0/1.
REQ-036 Rewrite the mask on the exact wrap cycle -> phase=0, count=0, no toggle; next toggle 4 cycles later.
REQ-037 Assert reset mid-blink with data 0x5555 -> out_port=RESET_VALUE and readdata=0 immediately; blinking stays off until the mask is rewritten.

Source files
------------

// File: rtl/lab7_soc_pio_pkg.sv
// Shared register map and byte-lane helper for the LED PIO slave.
package lab7_soc_pio_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned LANES = 4;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_SET  = 2'd2;
    localparam logic [1:0] ADDR_CLR  = 2'd3;

    // Take new_val in enabled byte lanes, keep old_val elsewhere.
    function automatic logic [BUS_W-1:0] merge_lanes(
        input logic [BUS_W-1:0] old_val,
        input logic [BUS_W-1:0] new_val,
        input logic [LANES-1:0] byteenable
    );
        logic [BUS_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(LANES); i++) begin
            if (byteenable[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lab7_soc_blink_prescaler.sv
// Free-running divider producing the blink phase; restart realigns it to 0.
module lab7_soc_blink_prescaler #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Restart wins over a wrap landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lab7_soc_leds.sv
// Avalon-MM LED PIO with set/clear aliases and a per-bit blink mask.
module lab7_soc_leds
    import lab7_soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int unsigned BLINK_DIV   = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [3:0]       byteenable,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] blink_mask;
    logic             phase;
    logic             wr_en;
    logic             mask_wr;
    logic [31:0]      data_ext;
    logic [31:0]      mask_ext;

    assign wr_en    = chipselect & ~write_n;
    assign mask_wr  = wr_en & (address == ADDR_MASK);
    assign data_ext = 32'(data_reg);
    assign mask_ext = 32'(blink_mask);

    lab7_soc_blink_prescaler #(
        .BLINK_DIV(BLINK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .restart(mask_wr),
        .phase  (phase)
    );

    // Register writes; readdata samples pre-write state every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg   <= WIDTH'(RESET_VALUE);
            blink_mask <= '0;
            readdata   <= '0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_DATA: data_reg   <= WIDTH'(merge_lanes(data_ext, writedata, byteenable));
                    ADDR_MASK: blink_mask <= WIDTH'(merge_lanes(mask_ext, writedata, byteenable));
                    ADDR_SET:  data_reg   <= WIDTH'(merge_lanes(data_ext, data_ext | writedata, byteenable));
                    ADDR_CLR:  data_reg   <= WIDTH'(merge_lanes(data_ext, data_ext & ~writedata, byteenable));
                endcase
            end
            case (address)
                ADDR_DATA: readdata <= data_ext;
                ADDR_MASK: readdata <= mask_ext;
                ADDR_SET:  readdata <= {31'b0, phase};
                ADDR_CLR:  readdata <= '0;
            endcase
        end
    end

    assign out_port = data_reg ^ (blink_mask & {WIDTH{phase}});

endmodule

// File: tb/tb_lab7_soc_leds.sv
// Scoreboard bench: cycle-level reference model feeds a queue drained by a monitor.
module tb_lab7_soc_leds;

    localparam int unsigned WIDTH = 16;
    localparam logic [31:0] RV    = 32'h0000_0C3A;
    localparam int unsigned DIV   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [3:0]       byteenable;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0]      rd;
        logic [WIDTH-1:0] led;
    } exp_t;

    exp_t exp_q[$];

    lab7_soc_leds #(
        .WIDTH(WIDTH),
        .RESET_VALUE(RV),
        .BLINK_DIV(DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .byteenable(byteenable),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: phase derived from cycles elapsed since the last realign.
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    int               m_t;

    function automatic logic phase_of(input int t);
        return ((t / int'(DIV)) % 2) == 1;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            m_data = WIDTH'(RV);
            m_mask = '0;
            m_t    = 0;
            e.rd   = '0;
        end else begin
            case (address)
                2'd0:    e.rd = 32'(m_data);
                2'd1:    e.rd = 32'(m_mask);
                2'd2:    e.rd = phase_of(m_t) ? 32'd1 : 32'd0;
                default: e.rd = '0;
            endcase
            if (chipselect && !write_n) begin
                for (int b = 0; b < int'(WIDTH); b++) begin
                    if (byteenable[b/8]) begin
                        case (address)
                            2'd0:    m_data[b] = writedata[b];
                            2'd1:    m_mask[b] = writedata[b];
                            2'd2:    if (writedata[b]) m_data[b] = 1'b1;
                            default: if (writedata[b]) m_data[b] = 1'b0;
                        endcase
                    end
                end
            end
            if (chipselect && !write_n && address == 2'd1) m_t = 0;
            else m_t = m_t + 1;
        end
        e.led = m_data ^ (phase_of(m_t) ? m_mask : '0);
        exp_q.push_back(e);
    end

    // Monitor: one expected response per clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_readdata", readdata, e.rd);
            chk("sb_out_port", 32'(out_port), 32'(e.led));
        end
    end

    // Drive one bus cycle, then return at the following falling edge.
    task automatic cyc(input logic [1:0] a, input logic cs, input logic wn,
                       input logic [31:0] d, input logic [3:0] be);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = d;
        byteenable = be;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(a, 1'b1, 1'b0, d, be);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(a, 1'b1, 1'b1, $urandom, 4'($urandom));
    endtask

    task automatic idle(input logic [1:0] a);
        cyc(a, 1'b0, 1'($urandom), $urandom, 4'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        byteenable = '0;
        repeat (2) @(negedge clk);
        chk("reset_out_port", 32'(out_port), 32'h0C3A);
        chk("reset_readdata", readdata, 32'h0);
        #1 reset = 1'b0;

        // Partial-lane write then readback
        wr(2'd0, 32'h0000_00A5, 4'b0011);
        chk("wr_a5_out", 32'(out_port), 32'h00A5);
        rd(2'd0);
        chk("rd_a5", readdata, 32'h0000_00A5);

        // Set / clear aliases
        wr(2'd0, 32'h0000_00F0, 4'b1111);
        wr(2'd2, 32'h0000_0003, 4'b1111);
        chk("set_out", 32'(out_port), 32'h00F3);
        wr(2'd3, 32'h0000_0010, 4'b1111);
        chk("clr_out", 32'(out_port), 32'h00E3);

        // Single lane merge
        wr(2'd0, 32'h0000_1234, 4'b1111);
        wr(2'd0, 32'h0000_FFFF, 4'b0010);
        chk("lane_merge", 32'(out_port), 32'hFF34);

        // Blink bit0 with period 2*DIV
        wr(2'd0, 32'h0, 4'b1111);
        wr(2'd1, 32'h1, 4'b1111);
        chk("blink_k0", 32'(out_port), 32'h0);
        for (int k = 1; k <= 11; k++) begin
            rd(2'd2);
            chk("blink_out", 32'(out_port), ((k / 4) % 2 == 1) ? 32'h1 : 32'h0);
            chk("blink_rd", readdata, (((k - 1) / 4) % 2 == 1) ? 32'h1 : 32'h0);
        end

        // Mask rewrite on the wrap edge suppresses the toggle
        wr(2'd1, 32'h1, 4'b1111);
        chk("wrap_restart", 32'(out_port), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            rd(2'd2);
            chk("post_restart", 32'(out_port), (k == 4) ? 32'h1 : 32'h0);
        end

        // Reset mid-blink
        wr(2'd0, 32'h0000_5555, 4'b1111);
        wr(2'd1, 32'h0000_FFFF, 4'b1111);
        repeat (5) rd(2'd0);
        #1 reset = 1'b1;
        #1;
        chk("mid_reset_out", 32'(out_port), 32'h0C3A);
        chk("mid_reset_rd", readdata, 32'h0);
        idle(2'd0);
        idle(2'd1);
        #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rd(2'd1);
            chk("post_reset_static", 32'(out_port), 32'h0C3A);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 4)      wr(2'($urandom), $urandom, 4'($urandom));
            else if (r < 7) rd(2'($urandom));
            else            idle(2'($urandom));
        end

        idle(2'd0);
        idle(2'd0);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
